// File: rtl/snn_input_loader.sv
// Receives a binary image byte-stream from a UART, unpacks each byte LSB-first
// into a 1-bit pixel RAM, then hands the completed frame to the SNN core.
module snn_input_loader #(
    parameter int unsigned NUM_BYTES = 98,
    parameter int unsigned GAP_CYC   = 26040
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    output logic       ram_we,
    output logic [9:0] ram_addr,
    output logic       ram_din,
    input  logic       core_busy,
    output logic       core_start,
    output logic       loading,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    localparam logic [6:0]    LAST_IDX = 7'(NUM_BYTES - 1);

    typedef enum logic [2:0] {IDLE, UNPACK, WAIT_BYTE, START, WAIT_CORE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [6:0]    byte_idx_q, byte_idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          busy_seen_q, busy_seen_d;
    logic          ram_we_q, ram_we_d;
    logic [9:0]    ram_addr_q, ram_addr_d;
    logic          ram_din_q, ram_din_d;
    logic          core_start_q, core_start_d;
    logic          loading_q, loading_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic [2:0]    nxt_bit;

    assign nxt_bit = bit_cnt_q + 3'd1;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        byte_idx_d   = byte_idx_q;
        gap_d        = gap_q;
        busy_seen_d  = busy_seen_q;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_din_d    = ram_din_q;
        core_start_d = 1'b0;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;

        case (state_q)
            // Bit 0 is issued on the latching edge so the registered write of
            // bit k lands k+1 cycles after the rx_rdy cycle.
            IDLE, WAIT_BYTE: begin
                if (rx_rdy) begin
                    shift_d    = {1'b0, rx_data[7:1]};
                    bit_cnt_d  = 3'd0;
                    ram_we_d   = 1'b1;
                    ram_din_d  = rx_data[0];
                    ram_addr_d = {byte_idx_q, 3'd0};
                    state_d    = UNPACK;
                end else if (state_q == WAIT_BYTE) begin
                    if (gap_q == GAP_LAST) begin
                        frame_err_d = 1'b1;
                        byte_idx_d  = '0;
                        state_d     = IDLE;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            UNPACK: begin
                overrun_d = rx_rdy;
                if (bit_cnt_q != 3'd7) begin
                    bit_cnt_d  = nxt_bit;
                    ram_we_d   = 1'b1;
                    ram_din_d  = shift_q[0];
                    ram_addr_d = {byte_idx_q, nxt_bit};
                    shift_d    = {1'b0, shift_q[7:1]};
                end else if (byte_idx_q == LAST_IDX) begin
                    byte_idx_d   = '0;
                    core_start_d = 1'b1;
                    state_d      = START;
                end else begin
                    byte_idx_d = byte_idx_q + 7'd1;
                    gap_d      = '0;
                    state_d    = WAIT_BYTE;
                end
            end
            START: begin
                overrun_d   = rx_rdy;
                busy_seen_d = 1'b0;
                state_d     = WAIT_CORE;
            end
            WAIT_CORE: begin
                overrun_d = rx_rdy;
                if (busy_seen_q && !core_busy) begin
                    state_d = IDLE;
                end else if (core_busy) begin
                    busy_seen_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        loading_d = (state_d == UNPACK) || (state_d == WAIT_BYTE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            byte_idx_q   <= '0;
            gap_q        <= '0;
            busy_seen_q  <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_din_q    <= 1'b0;
            core_start_q <= 1'b0;
            loading_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_idx_q   <= byte_idx_d;
            gap_q        <= gap_d;
            busy_seen_q  <= busy_seen_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            core_start_q <= core_start_d;
            loading_q    <= loading_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_din    = ram_din_q;
    assign core_start = core_start_q;
    assign loading    = loading_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule
